// File: rtl/alu_writeback.sv
// ALU write-back stage: in-order result FIFO draining into an 8x16 register file,
// sharing the single write port with a higher-priority memory-load path.
module alu_writeback #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                alu_result,
    input  logic [2:0]                 alu_dest,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [15:0]                ld_data,
    input  logic [2:0]                 ld_dest,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [2:0]                 rd_addr_a,
    input  logic [2:0]                 rd_addr_b,
    output logic [15:0]                rd_data_a,
    output logic [15:0]                rd_data_b,
    output logic [7:0]                 busy_mask,
    output logic [$clog2(DEPTH):0]     wb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [15:0]   fifo_data_q [DEPTH];
    logic [2:0]    fifo_dest_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   rf_q [8];

    logic          alu_xfer, ld_xfer, pop;
    logic          wr_en;
    logic [2:0]    wr_addr;
    logic [15:0]   wr_data;
    logic [PW-1:0] off;

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        busy_mask = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q)
                busy_mask[fifo_dest_q[i]] = 1'b1;
        end
    end

    assign alu_ready = !rst && (count_q < CW'(DEPTH));
    assign ld_ready  = !rst && !busy_mask[ld_dest];
    assign wb_count  = count_q;

    assign alu_xfer = alu_valid && alu_ready;
    assign ld_xfer  = ld_valid && ld_ready;
    assign pop      = !rst && (count_q != '0) && !ld_xfer;

    assign wr_en   = ld_xfer || pop;
    assign wr_addr = ld_xfer ? ld_dest : fifo_dest_q[head_q];
    assign wr_data = ld_xfer ? ld_data : fifo_data_q[head_q];

    always_comb begin
        head_d  = pop ? head_q + 1'b1 : head_q;
        tail_d  = alu_xfer ? tail_q + 1'b1 : tail_q;
        count_d = count_q;
        case ({alu_xfer, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    function automatic logic [15:0] rd_port(input logic [2:0] addr);
        if (addr == 3'd0)
            return 16'h0;
        else if (wr_en && addr == wr_addr)
            return wr_data;
        else
            return rf_q[addr];
    endfunction

    assign rd_data_a = rd_port(rd_addr_a);
    assign rd_data_b = rd_port(rd_addr_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < 8; i++)
                rf_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // r0 is hardwired; pops to r0 still consume the entry.
            if (wr_en && wr_addr != 3'd0)
                rf_q[wr_addr] <= wr_data;
        end
    end

    // Payload storage needs no reset: liveness comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (alu_xfer) begin
            fifo_data_q[tail_q] <= alu_result;
            fifo_dest_q[tail_q] <= alu_dest;
        end
    end

endmodule
